// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver with double-buffered frames,
// hex/decimal glyphs, leading-zero blanking, per-digit blink and PWM brightness.
module seven_seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_LOG2   = 18,
  parameter int PWM_BITS     = 4,
  parameter int BLINK_FRAMES = 48
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_load,
  output logic                    o_load_ack,
  input  logic [NUM_DIGITS-1:0]   i_blink,
  input  logic                    i_blank_lz,
  input  logic                    i_hex_mode,
  input  logic [PWM_BITS-1:0]     i_brightness,
  output logic [NUM_DIGITS-1:0]   o_anode,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame_start
);

  localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0]         POS_LAST  = PW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0]         FRM_LAST  = FW'(BLINK_FRAMES - 1);
  localparam logic [DIGIT_LOG2-1:0] SLOT_LAST = '1;

  logic [DIGIT_LOG2-1:0]   slot_q, slot_d;
  logic [PW-1:0]           pos_q, pos_d;
  logic [FW-1:0]           frame_cnt_q, frame_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    load_ack_q, load_ack_d;
  logic                    frame_start_q, frame_start_d;

  logic          slot_wrap, frame_first, frame_last, commit;
  logic [PW-1:0] cur;
  logic [3:0]    nib;
  logic          cur_dp, cur_blink, cur_blank, run, lit;

  function automatic logic [6:0] glyph(input logic [3:0] v, input logic hex);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    if (!hex && v > 4'h9) g = 7'b0111111;
    return g;
  endfunction

  // Counters, frame bookkeeping and buffer handshake
  always_comb begin
    slot_wrap   = (slot_q == SLOT_LAST);
    frame_first = (slot_q == '0) && (pos_q == '0);
    frame_last  = slot_wrap && (pos_q == POS_LAST);
    commit      = frame_first && pend_flag_q;

    slot_d = slot_q + 1'b1;
    pos_d  = pos_q;
    if (slot_wrap) pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;

    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_last) begin
      if (frame_cnt_q == FRM_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    // Committed data is used on the very cycle it is committed, so no frame tears.
    act_digits_d = commit ? pend_digits_q : act_digits_q;
    act_dp_d     = commit ? pend_dp_q     : act_dp_q;

    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_flag_d   = pend_flag_q;
    if (i_load) begin
      pend_digits_d = i_digits;
      pend_dp_d     = i_dp;
      pend_flag_d   = 1'b1;
    end else if (commit) begin
      pend_flag_d = 1'b0;
    end

    load_ack_d    = commit;
    frame_start_d = frame_first;
  end

  // Display decode for the digit being scanned (pos 0 is the leftmost digit)
  always_comb begin
    cur       = POS_LAST - pos_q;
    nib       = 4'd0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_blank = 1'b0;
    run       = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run = run & (act_digits_d[4*k +: 4] == 4'd0);
      if (cur == PW'(k)) begin
        nib       = act_digits_d[4*k +: 4];
        cur_dp    = act_dp_d[k];
        cur_blink = i_blink[k];
        cur_blank = run && (k != 0);
      end
    end

    lit     = slot_q[DIGIT_LOG2-1 -: PWM_BITS] < i_brightness;
    anode_d = '1;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    if (lit) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (cur == PW'(k)) anode_d[k] = 1'b0;
      end
      if (!(blink_phase_q && cur_blink)) begin
        dp_d = ~cur_dp;
        if (!(i_blank_lz && cur_blank)) seg_d = glyph(nib, i_hex_mode);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      slot_q        <= '0;
      pos_q         <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      act_digits_q  <= '0;
      act_dp_q      <= '0;
      pend_digits_q <= '0;
      pend_dp_q     <= '0;
      pend_flag_q   <= 1'b0;
      anode_q       <= '1;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      pos_q         <= pos_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      act_digits_q  <= act_digits_d;
      act_dp_q      <= act_dp_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_flag_q   <= pend_flag_d;
      anode_q       <= anode_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      load_ack_q    <= load_ack_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_anode       = anode_q;
  assign o_seg         = seg_q;
  assign o_dp          = dp_q;
  assign o_load_ack    = load_ack_q;
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: a time-based reference model predicts every
// output cycle, and a negedge monitor pops and compares.
module tb_seven_seg_scan;
  localparam int N     = 4;
  localparam int L     = 4;
  localparam int P     = 2;
  localparam int BF    = 2;
  localparam int SLOT  = 1 << L;
  localparam int FRAME = N * SLOT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [4*N-1:0] digits;
  logic [N-1:0]   dp_in;
  logic           load;
  logic           load_ack;
  logic [N-1:0]   blink;
  logic           blank_lz;
  logic           hex_mode;
  logic [P-1:0]   bright;
  logic [N-1:0]   anode;
  logic [6:0]     seg;
  logic           dp_out;
  logic           frame_start;

  seven_seg_scan #(.NUM_DIGITS(N), .DIGIT_LOG2(L), .PWM_BITS(P), .BLINK_FRAMES(BF)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_digits(digits), .i_dp(dp_in), .i_load(load),
    .o_load_ack(load_ack), .i_blink(blink), .i_blank_lz(blank_lz), .i_hex_mode(hex_mode),
    .i_brightness(bright), .o_anode(anode), .o_seg(seg), .o_dp(dp_out),
    .o_frame_start(frame_start)
  );

  typedef struct {
    int          cyc;
    logic [15:0] d;
    logic [3:0]  dp;
  } load_t;

  load_t       loads[$];
  logic [13:0] exp_q[$];
  int          exp_cyc[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          c = 0;

  logic [6:0] glyph_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Expected outputs one cycle after scan position cy (cycles since reset release).
  function automatic logic [13:0] model(int cy);
    int          f, off, d, slot, val;
    logic [15:0] act;
    logic [3:0]  adp;
    logic        ack, lit, zero_above, blanked, dark;
    logic [3:0]  an;
    logic [6:0]  sg;
    logic        dpo;
    f    = cy / FRAME;
    off  = cy % FRAME;
    d    = N - 1 - off / SLOT;
    slot = off % SLOT;
    act  = 16'h0;
    adp  = 4'h0;
    ack  = 1'b0;
    foreach (loads[i]) begin
      if (loads[i].cyc < f * FRAME) begin
        act = loads[i].d;
        adp = loads[i].dp;
      end
      if (off == 0 && f > 0 && loads[i].cyc >= (f - 1) * FRAME && loads[i].cyc < f * FRAME)
        ack = 1'b1;
    end
    lit = (slot >> (L - P)) < int'(bright);
    zero_above = 1'b1;
    for (int j = N - 1; j >= d; j--)
      if (((act >> (4 * j)) & 16'hF) != 16'h0) zero_above = 1'b0;
    blanked = blank_lz && (d != 0) && zero_above;
    dark    = ((f / BF) % 2 == 1) && blink[d];
    val     = int'((act >> (4 * d)) & 16'hF);
    sg      = (val < 10 || hex_mode) ? glyph_tab[val] : 7'b0111111;
    an      = lit ? ~(4'b0001 << d) : 4'hF;
    if (!lit || dark || blanked) sg = 7'h7F;
    dpo = (lit && !dark && adp[d]) ? 1'b0 : 1'b1;
    return {an, sg, dpo, ack, (off == 0)};
  endfunction

  task automatic step();
    if (!rst_n) begin
      exp_q.push_back({4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
      exp_cyc.push_back(-1);
      loads.delete();
      c = 0;
    end else begin
      if (load) loads.push_back('{c, digits, dp_in});
      exp_q.push_back(model(c));
      exp_cyc.push_back(c);
      c++;
    end
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic run_to(int off);
    for (int i = 0; i < FRAME; i++) begin
      if (c % FRAME == off) break;
      step();
    end
  endtask

  task automatic do_load(logic [15:0] d, logic [3:0] p);
    digits = d;
    dp_in  = p;
    load   = 1'b1;
    step();
  endtask

  initial begin : monitor
    logic [13:0] e, got;
    int          ec;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        ec  = exp_cyc.pop_front();
        got = {anode, seg, dp_out, load_ack, frame_start};
        vectors++;
        if (got !== e) begin
          miscompares++;
          if (miscompares <= 40)
            $display("FAIL out cyc=%0d anode/seg/dp/ack/fs got %b %b %b %b %b want %b %b %b %b %b",
                     ec, got[13:10], got[9:3], got[2], got[1], got[0],
                     e[13:10], e[9:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0; load = 1'b0; digits = '0; dp_in = '0;
    blink = '0; blank_lz = 1'b0; hex_mode = 1'b0; bright = 2'd3;
    run(5);
    rst_n = 1'b1;
    run(2 * FRAME);

    run_to(20);
    do_load(16'h1234, 4'h0);
    run(2 * FRAME);

    blank_lz = 1'b1;
    run_to(10);
    do_load(16'h0001, 4'h0);
    run(5);
    do_load(16'h00A5, 4'h0);
    run(2 * FRAME);
    hex_mode = 1'b1;
    run(FRAME);
    do_load(16'h0000, 4'h0);
    run(2 * FRAME);

    // load just before a commit, then one exactly on the commit cycle
    run_to(FRAME - 1);
    do_load(16'h1234, 4'h3);
    do_load(16'h5678, 4'h8);
    run(2 * FRAME);

    blank_lz = 1'b0;
    blink = 4'b0001;
    do_load(16'h1234, 4'b0100);
    run(8 * FRAME);

    bright = 2'd0;
    run(FRAME);
    bright = 2'd3;
    blink = '0;

    run_to(30);
    do_load(16'h9999, 4'hF);
    rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(2 * FRAME);

    for (int i = 0; i < 40 * FRAME; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        digits = 16'($urandom);
        dp_in  = 4'($urandom);
        load   = 1'b1;
      end
      if ($urandom_range(0, 31) == 0) begin
        bright   = 2'($urandom);
        blink    = 4'($urandom);
        hex_mode = 1'($urandom);
        blank_lz = 1'($urandom);
      end
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
      end
      step();
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
